// File: rtl/psx_video_pkg.sv
// Shared types and helpers for the PSX video path: unpacker states, RGB888 pixel,
// and RGB555 -> RGB888 expansion.
package psx_video_pkg;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2
  } unpack_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps 5'h00 -> 8'h00 and 5'h1F -> 8'hFF.
  function automatic logic [7:0] expand5to8(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic rgb888_t unpack555(input logic [15:0] w);
    rgb888_t p;
    p.r = expand5to8(w[4:0]);
    p.g = expand5to8(w[9:5]);
    p.b = expand5to8(w[14:10]);
    return p;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty derive from the registered occupancy.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/psx_pixel_feeder.sv
// Buffers VRAM halfwords, unpacks RGB555 or packed RGB888 pixels and feeds the
// HDMI top through a valid/ready output register; counts output underruns.
module psx_pixel_feeder
  import psx_video_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          depth24,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_rdy,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          video_valid,
  input  logic          video_rdy,
  output logic [LW-1:0] level,
  output logic [15:0]   underrun_cnt
);

  logic          fifo_full;
  logic          fifo_empty;
  logic [15:0]   fifo_rdata;
  logic          push;
  logic          pop;
  logic          can_load;

  unpack_state_t state_q, state_d;
  logic          mode_q;
  logic [7:0]    r0_q, r0_d;
  logic [7:0]    g0_q, g0_d;
  logic [7:0]    r1_q, r1_d;
  rgb888_t       pix_q, pix_d;
  logic          vv_q, vv_d;
  logic          running_q;
  logic          init_q;
  logic [15:0]   under_q;

  assign push = in_valid && in_rdy && !flush;

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(16),
    .LW   (LW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .push (push),
    .pop  (pop),
    .wdata(in_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(level)
  );

  // W0 only stashes bytes, so it may pop even while the output register is stalled.
  always_comb begin
    can_load = !vv_q || video_rdy;
    pop      = 1'b0;
    state_d  = state_q;
    r0_d     = r0_q;
    g0_d     = g0_q;
    r1_d     = r1_q;
    pix_d    = pix_q;
    vv_d     = can_load ? 1'b0 : vv_q;
    if (!mode_q) begin
      if (!fifo_empty && can_load) begin
        pop   = 1'b1;
        pix_d = unpack555(fifo_rdata);
        vv_d  = 1'b1;
      end
    end else begin
      case (state_q)
        W0: if (!fifo_empty) begin
          pop     = 1'b1;
          r0_d    = fifo_rdata[7:0];
          g0_d    = fifo_rdata[15:8];
          state_d = W1;
        end
        W1: if (!fifo_empty && can_load) begin
          pop     = 1'b1;
          pix_d   = '{r: r0_q, g: g0_q, b: fifo_rdata[7:0]};
          vv_d    = 1'b1;
          r1_d    = fifo_rdata[15:8];
          state_d = W2;
        end
        W2: if (!fifo_empty && can_load) begin
          pop     = 1'b1;
          pix_d   = '{r: r1_q, g: fifo_rdata[7:0], b: fifo_rdata[15:8]};
          vv_d    = 1'b1;
          state_d = W0;
        end
        default: state_d = W0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q   <= W0;
      mode_q    <= rst ? 1'b0 : depth24;
      r0_q      <= '0;
      g0_q      <= '0;
      r1_q      <= '0;
      pix_q     <= '0;
      vv_q      <= 1'b0;
      running_q <= 1'b0;
      init_q    <= 1'b0;
      if (rst) under_q <= '0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      g0_q    <= g0_d;
      r1_q    <= r1_d;
      pix_q   <= pix_d;
      vv_q    <= vv_d;
      init_q  <= 1'b1;
      if (vv_q && video_rdy) running_q <= 1'b1;
      if (running_q && video_rdy && !vv_q && (under_q != '1)) begin
        under_q <= under_q + 16'd1;
      end
    end
  end

  assign in_rdy       = init_q && !fifo_full;
  assign r            = pix_q.r;
  assign g            = pix_q.g;
  assign b            = pix_q.b;
  assign video_valid  = vv_q;
  assign underrun_cnt = under_q;

endmodule
